// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between instruction fetch and load/store
// Optional macro ARB_TIMEOUT_EN: abort a BUSY transaction after TIMEOUT cycles without memAck.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              iReq,
   input  logic [ADDR_W-1:0] iAddr,
   output logic              iValid,
   output logic [DATA_W-1:0] iRdata,
   input  logic              dReq,
   input  logic              dWe,
   input  logic [ADDR_W-1:0] dAddr,
   input  logic [DATA_W-1:0] dWdata,
   output logic              dValid,
   output logic [DATA_W-1:0] dRdata,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWdata,
   input  logic [DATA_W-1:0] memRdata,
   input  logic              memAck,
   output logic              busy,
   output logic              gntId,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT must be 1..255");
   end

   state_t            state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              gnt_id_q, gnt_id_d;
   logic              last_gnt_q, last_gnt_d;
   logic              i_valid_q, i_valid_d;
   logic              d_valid_q, d_valid_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              pick_data;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT - 1);
   logic [7:0] cnt_q, cnt_d;
`endif

   // On a tie the requester that did not win last time gets the memory.
   assign pick_data = dReq && (!iReq || !last_gnt_q);

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      gnt_id_d    = gnt_id_q;
      last_gnt_d  = last_gnt_q;
      i_valid_d   = 1'b0;
      d_valid_d   = 1'b0;
      busy_d      = busy_q;
      err_d       = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (iReq || dReq) begin
               gnt_id_d    = pick_data;
               last_gnt_d  = pick_data;
               mem_addr_d  = pick_data ? dAddr : iAddr;
               mem_we_d    = pick_data & dWe;
               mem_wdata_d = pick_data ? dWdata : '0;
               mem_req_d   = 1'b1;
               busy_d      = 1'b1;
               state_d     = BUSY;
`ifdef ARB_TIMEOUT_EN
               cnt_d       = 8'd0;
`endif
            end
         end
         BUSY: begin
            if (memAck) begin
               if (!mem_we_q) rdata_d = memRdata;
               mem_req_d = 1'b0;
               i_valid_d = !gnt_id_q;
               d_valid_d = gnt_id_q;
               state_d   = RESP;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == TIMEOUT_LIM) begin
               rdata_d   = DATA_W'(32'hDEADBEEF);
               mem_req_d = 1'b0;
               i_valid_d = !gnt_id_q;
               d_valid_d = gnt_id_q;
               err_d     = 1'b1;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         RESP: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            mem_req_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         gnt_id_q    <= 1'b0;
         last_gnt_q  <= 1'b0;
         i_valid_q   <= 1'b0;
         d_valid_q   <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q       <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         gnt_id_q    <= gnt_id_d;
         last_gnt_q  <= last_gnt_d;
         i_valid_q   <= i_valid_d;
         d_valid_q   <= d_valid_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign memReq   = mem_req_q;
   assign memWe    = mem_we_q;
   assign memAddr  = mem_addr_q;
   assign memWdata = mem_wdata_q;
   assign iValid   = i_valid_q;
   assign dValid   = d_valid_q;
   assign iRdata   = rdata_q;
   assign dRdata   = rdata_q;
   assign busy     = busy_q;
   assign gntId    = gnt_id_q;
   assign err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        resetN;
   logic        iReq, dReq, dWe, memAck;
   logic [31:0] iAddr, dAddr, dWdata, memRdata;
   logic        iValid, dValid, memReq, memWe, busy, gntId, err;
   logic [31:0] iRdata, dRdata, memAddr, memWdata;
   int          errors = 0;
   int          checks = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .resetN(resetN),
      .iReq(iReq), .iAddr(iAddr), .iValid(iValid), .iRdata(iRdata),
      .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
      .dValid(dValid), .dRdata(dRdata),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
      .memRdata(memRdata), .memAck(memAck),
      .busy(busy), .gntId(gntId), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      resetN = 1'b0; iReq = 0; dReq = 0; dWe = 0; memAck = 0;
      iAddr = '0; dAddr = '0; dWdata = '0; memRdata = '0;
      tick(); tick();
      chk("rst_memReq", {31'd0, memReq}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valids", {30'd0, iValid, dValid}, 32'd0);
      chk("rst_gnt_err", {30'd0, gntId, err}, 32'd0);
      chk("rst_memAddr", memAddr, 32'd0);
      chk("rst_rdata", iRdata, 32'd0);
      resetN = 1'b1;
      tick();

      // single fetch, ack in first BUSY cycle
      iReq = 1; iAddr = 32'h100;
      tick();
      chk("f_memReq", {31'd0, memReq}, 32'd1);
      chk("f_memAddr", memAddr, 32'h100);
      chk("f_memWe", {31'd0, memWe}, 32'd0);
      chk("f_busy", {31'd0, busy}, 32'd1);
      chk("f_iValid_early", {31'd0, iValid}, 32'd0);
      memAck = 1; memRdata = 32'h8000_1234;
      tick();
      chk("f_iValid", {31'd0, iValid}, 32'd1);
      chk("f_iRdata", iRdata, 32'h8000_1234);
      chk("f_dValid", {31'd0, dValid}, 32'd0);
      chk("f_memReq_drop", {31'd0, memReq}, 32'd0);
      iReq = 0;
      tick();
      chk("f_iValid_width", {31'd0, iValid}, 32'd0);
      // stray ack while idle must not start anything
      tick();
      chk("stray_busy", {31'd0, busy}, 32'd0);
      chk("stray_valids", {30'd0, iValid, dValid}, 32'd0);
      memAck = 0;

      // simultaneous requests: data, instr, data, instr
      iReq = 1; iAddr = 32'h300; dReq = 1; dWe = 0; dAddr = 32'h200;
      for (int k = 0; k < 4; k++) begin
         logic exp_g;
         exp_g = (k % 2 == 0);
         tick();
         chk("tie_gnt", {31'd0, gntId}, {31'd0, exp_g});
         chk("tie_addr", memAddr, exp_g ? 32'h200 : 32'h300);
         tick();
         chk("tie_wait_req", {31'd0, memReq}, 32'd1);
         chk("tie_wait_valids", {30'd0, iValid, dValid}, 32'd0);
         memAck = 1; memRdata = 32'h1000 + k;
         tick();
         chk("tie_valids", {30'd0, iValid, dValid}, {30'd0, !exp_g, exp_g});
         chk("tie_rdata", exp_g ? dRdata : iRdata, 32'h1000 + k);
         memAck = 0;
         tick();
         chk("tie_valid_width", {30'd0, iValid, dValid}, 32'd0);
      end
      iReq = 0; dReq = 0;
      tick();

      // store
      dReq = 1; dWe = 1; dAddr = 32'h40; dWdata = 32'hCAFE_F00D;
      tick();
      chk("st_memWe", {31'd0, memWe}, 32'd1);
      chk("st_memWdata", memWdata, 32'hCAFE_F00D);
      chk("st_memAddr", memAddr, 32'h40);
      chk("st_gnt", {31'd0, gntId}, 32'd1);
      tick();
      chk("st_hold", {31'd0, memReq, memWe} == 2'b11 ? memWdata : 32'd0, 32'hCAFE_F00D);
      memAck = 1; memRdata = 32'h5555_5555;
      tick();
      chk("st_dValid", {31'd0, dValid}, 32'd1);
      chk("st_dRdata_kept", dRdata, 32'h1003);
      dReq = 0; dWe = 0; memAck = 0;
      tick();
      chk("st_dValid_width", {31'd0, dValid}, 32'd0);
      tick();

      // reset mid-BUSY
      iReq = 1; iAddr = 32'h500;
      tick();
      chk("rb_memReq", {31'd0, memReq}, 32'd1);
      resetN = 1'b0;
      #1;
      chk("rb_memReq_drop", {31'd0, memReq}, 32'd0);
      chk("rb_busy", {31'd0, busy}, 32'd0);
      chk("rb_valids", {30'd0, iValid, dValid}, 32'd0);
      iReq = 0;
      tick();
      resetN = 1'b1;
      tick(); tick();
      chk("rb_idle_req", {31'd0, memReq}, 32'd0);
      chk("rb_idle_busy", {31'd0, busy}, 32'd0);

      // load without ack
      dReq = 1; dWe = 0; dAddr = 32'h80;
      tick();
      chk("to_memReq", {31'd0, memReq}, 32'd1);
`ifdef ARB_TIMEOUT_EN
      tick(); tick(); tick();
      chk("to_still_req", {31'd0, memReq}, 32'd1);
      chk("to_no_err_yet", {31'd0, err}, 32'd0);
      tick();
      chk("to_memReq_drop", {31'd0, memReq}, 32'd0);
      chk("to_dValid_err", {30'd0, dValid, err}, 32'd3);
      chk("to_dRdata", dRdata, 32'hDEAD_BEEF);
      dReq = 0;
      tick();
      chk("to_err_width", {30'd0, dValid, err}, 32'd0);
`else
      for (int c = 0; c < 20; c++) tick();
      chk("nto_memReq_held", {31'd0, memReq}, 32'd1);
      chk("nto_err", {31'd0, err}, 32'd0);
      chk("nto_no_valid", {31'd0, dValid}, 32'd0);
      memAck = 1; memRdata = 32'h0BAD_F00D;
      tick();
      chk("nto_dValid", {30'd0, dValid, err}, 32'd2);
      chk("nto_dRdata", dRdata, 32'h0BAD_F00D);
      dReq = 0; memAck = 0;
      tick();
`endif
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
